// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back path.
package wb_pkg;

    localparam int unsigned ADDR_W_DEF     = 5;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 2;

    // Register 0 is hard-wired; writes to it are swallowed.
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
        logic                  is_load;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; DEPTH must be a power of two >= 2.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH   = FIFO_DEPTH_DEF,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic   [PW:0]   wr_ptr;
    logic   [PW:0]   rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full)
            mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-port arbiter (ALU over buffered loads) with pending-load scoreboard.
// Optional WB_BYPASS_EN adds write-port forwarding to the decode read ports.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     ld_issue,
    input  logic [ADDRESS_WIDTH-1:0] ld_rd,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic                     hazard,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] ad3,
    output logic [DATA_WIDTH-1:0]    WD3
`ifdef WB_BYPASS_EN
    ,
    output logic                     byp1_en,
    output logic [DATA_WIDTH-1:0]    byp1_data,
    output logic                     byp2_en,
    output logic [DATA_WIDTH-1:0]    byp2_data
`endif
);

    localparam int unsigned              NREGS = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] RZ    = REG_ZERO[ADDRESS_WIDTH-1:0];

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
        logic                     is_load;
    } wb_slot_t;

    wb_slot_t           fifo_in;
    wb_slot_t           fifo_head;
    wb_slot_t           sel;
    logic               sel_valid;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               is_load_q;
    logic [NREGS-1:0]   sb_q;
    logic [NREGS-1:0]   sb_d;
    logic               src1_hit;
    logic               src2_hit;

    assign mem_ready = !rst && !fifo_full;
    assign push      = mem_valid && mem_ready;
    assign pop       = !alu_valid && !fifo_empty;
    assign fifo_in   = '{rd: mem_rd, data: mem_data, is_load: 1'b1};

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (wb_slot_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        sel       = '{rd: alu_rd, data: alu_data, is_load: 1'b0};
        sel_valid = alu_valid;
        if (!alu_valid) begin
            sel       = fifo_head;
            sel_valid = !fifo_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WE3       <= 1'b0;
            ad3       <= '0;
            WD3       <= '0;
            is_load_q <= 1'b0;
        end else if (sel_valid) begin
            WE3       <= (sel.rd != RZ);
            ad3       <= sel.rd;
            WD3       <= sel.data;
            is_load_q <= sel.is_load;
        end else begin
            WE3       <= 1'b0;
            is_load_q <= 1'b0;
        end
    end

    // Clear first so a same-cycle re-issue to the same register stays pending.
    always_comb begin
        sb_d = sb_q;
        if (WE3 && is_load_q)
            sb_d[ad3] = 1'b0;
        if (ld_issue && ld_rd != RZ)
            sb_d[ld_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sb_q <= '0;
        else
            sb_q <= sb_d;
    end

    assign src1_hit = (rs1 != RZ) && sb_q[rs1];
    assign src2_hit = (rs2 != RZ) && sb_q[rs2];

`ifdef WB_BYPASS_EN
    assign byp1_en   = WE3 && (ad3 == rs1) && (rs1 != RZ);
    assign byp2_en   = WE3 && (ad3 == rs2) && (rs2 != RZ);
    assign byp1_data = WD3;
    assign byp2_data = WD3;
    assign hazard    = (src1_hit && !byp1_en) || (src2_hit && !byp2_en);
`else
    assign hazard    = src1_hit || src2_hit;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback; honours WB_BYPASS_EN when defined.
module tb_reg_writeback;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_issue;
    logic [AW-1:0] ld_rd;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          hazard;
    logic          WE3;
    logic [AW-1:0] ad3;
    logic [DW-1:0] WD3;
`ifdef WB_BYPASS_EN
    logic          byp1_en;
    logic [DW-1:0] byp1_data;
    logic          byp2_en;
    logic [DW-1:0] byp2_data;
`endif

    reg_writeback #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_issue  (ld_issue),
        .ld_rd     (ld_rd),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard    (hazard),
        .WE3       (WE3),
        .ad3       (ad3),
        .WD3       (WD3)
`ifdef WB_BYPASS_EN
        ,
        .byp1_en   (byp1_en),
        .byp1_data (byp1_data),
        .byp2_en   (byp2_en),
        .byp2_data (byp2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ld_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic          ld;
    } out_t;

    ld_t           mq[$];
    out_t          exp_q[$];
    out_t          cur;
    logic [31:0]   sb;
    int unsigned   checks;
    int unsigned   errors;

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, predict the edge, check registered outputs.
    task automatic step(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input bit li, input logic [AW-1:0] lrd,
                        input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2, output bit acc);
        out_t        nxt;
        out_t        exp;
        ld_t         e;
        logic [31:0] sb_n;
        bit          exp_rdy;
        bit          h1;
        bit          h2;
        assert (!(av && ard != 0 && sb[ard]))
            else $error("illegal ALU write to pending register %0d", ard);
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        ld_issue  = li;  ld_rd  = lrd;
        mem_valid = mv;  mem_rd = mrd;  mem_data = md;
        rs1 = r1;        rs2 = r2;
        #1;
        exp_rdy = (mq.size() < DEPTH);
        check_val("mem_ready", DW'(mem_ready), DW'(exp_rdy));
        h1 = (r1 != 0) && sb[r1];
        h2 = (r2 != 0) && sb[r2];
`ifdef WB_BYPASS_EN
        begin
            bit b1;
            bit b2;
            b1 = cur.we && cur.rd == r1 && r1 != 0;
            b2 = cur.we && cur.rd == r2 && r2 != 0;
            check_val("byp1_en", DW'(byp1_en), DW'(b1));
            check_val("byp2_en", DW'(byp2_en), DW'(b2));
            if (b1) check_val("byp1_data", byp1_data, cur.data);
            if (b2) check_val("byp2_data", byp2_data, cur.data);
            h1 = h1 && !b1;
            h2 = h2 && !b2;
        end
`endif
        check_val("hazard", DW'(hazard), DW'(h1 || h2));
        acc = mv && exp_rdy;
        if (av)
            nxt = '{we: (ard != 0), rd: ard, data: ad, ld: 1'b0};
        else if (mq.size() > 0) begin
            e   = mq.pop_front();
            nxt = '{we: (e.rd != 0), rd: e.rd, data: e.data, ld: 1'b1};
        end else
            nxt = '{we: 1'b0, rd: cur.rd, data: cur.data, ld: 1'b0};
        if (acc) mq.push_back('{rd: mrd, data: md});
        sb_n = sb;
        if (cur.we && cur.ld) sb_n[cur.rd] = 1'b0;
        if (li && lrd != 0)   sb_n[lrd]    = 1'b1;
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_val("WE3", DW'(WE3), DW'(exp.we));
        if (exp.we) begin
            check_val("ad3", DW'(ad3), DW'(exp.rd));
            check_val("WD3", WD3, exp.data);
        end
        cur = exp;
        sb  = sb_n;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bit acc;
        for (int unsigned i = 0; i < n; i++)
            step(0, '0, '0, 0, '0, 0, '0, '0, r1, r2, acc);
    endtask

    task automatic do_reset(input int unsigned n);
        rst = 1'b1;
        alu_valid = 0; alu_rd = '0; alu_data = '0; ld_issue = 0; ld_rd = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0; rs1 = '0; rs2 = '0;
        for (int unsigned i = 0; i < n; i++) begin
            #1;
            check_val("rst_mem_ready", DW'(mem_ready), '0);
            @(posedge clk);
            #1;
            check_val("rst_WE3", DW'(WE3), '0);
            check_val("rst_ad3", DW'(ad3), '0);
            check_val("rst_WD3", WD3, '0);
            @(negedge clk);
        end
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
        sb  = '0;
        cur = '{we: 1'b0, rd: '0, data: '0, ld: 1'b0};
    endtask

    // Offer loads in order while the ALU is busy for alu_cycles; the producer holds until accepted.
    task automatic burst(input int unsigned alu_cycles, input logic [AW-1:0] alu_base,
                         input int unsigned nloads, input logic [AW-1:0] ld_base,
                         input int unsigned cycles);
        int unsigned idx;
        bit          acc;
        idx = 0;
        for (int unsigned c = 0; c < cycles; c++) begin
            step(c < alu_cycles, alu_base + AW'(c), 32'hA000_0000 + DW'(c),
                 0, '0,
                 idx < nloads, ld_base + AW'(idx), 32'h0000_0100 + DW'(idx),
                 ld_base, ld_base + AW'(1), acc);
            if (acc) idx++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            acc;
        bit            mv_pend;
        bit            av;
        bit            li;
        logic [AW-1:0] ard;
        logic [AW-1:0] lrd;
        logic [AW-1:0] mrd;
        logic [DW-1:0] md;
        checks = 0;
        errors = 0;
        do_reset(2);

        // ALU write lands on the port one cycle after selection.
        step(1, 5'd5, 32'hDEAD_BEEF, 0, '0, 0, '0, '0, '0, '0, acc);
        idle(1, '0, '0);

        // Load to r7: pending until the cycle after its write.
        step(0, '0, '0, 1, 5'd7, 0, '0, '0, 5'd7, '0, acc);
        idle(1, 5'd7, '0);
        step(0, '0, '0, 0, '0, 1, 5'd7, 32'h12, 5'd7, '0, acc);
        idle(4, 5'd7, '0);

        // Three loads against a four-cycle ALU burst: back-pressure, in-order drain.
        step(0, '0, '0, 1, 5'd1, 0, '0, '0, '0, '0, acc);
        step(0, '0, '0, 1, 5'd2, 0, '0, '0, '0, '0, acc);
        step(0, '0, '0, 1, 5'd3, 0, '0, '0, '0, '0, acc);
        burst(4, 5'd10, 3, 5'd1, 10);
        idle(2, 5'd3, 5'd1);

        // Register 0 is never written nor tracked.
        step(1, '0, 32'hFF, 0, '0, 0, '0, '0, '0, '0, acc);
        step(0, '0, '0, 1, '0, 0, '0, '0, '0, '0, acc);
        step(0, '0, '0, 0, '0, 1, '0, 32'h55, '0, '0, acc);
        idle(3, '0, '0);

        // Reset with two loads buffered discards them and their pending bits.
        step(0, '0, '0, 1, 5'd4, 0, '0, '0, '0, '0, acc);
        step(0, '0, '0, 1, 5'd6, 0, '0, '0, '0, '0, acc);
        burst(2, 5'd20, 2, 5'd4, 2);
        check_val("buffered_before_rst", DW'(mq.size()), DW'(2));
        do_reset(1);
        idle(4, 5'd4, 5'd6);

        // Load to r3 written while decode reads rs2=3 (bypass case when enabled).
        step(0, '0, '0, 1, 5'd3, 0, '0, '0, '0, 5'd3, acc);
        step(0, '0, '0, 0, '0, 1, 5'd3, 32'h3333_0003, '0, 5'd3, acc);
        idle(4, '0, 5'd3);

        // Random legal traffic.
        mv_pend = 0;
        mrd = '0;
        md  = '0;
        for (int unsigned c = 0; c < 300; c++) begin
            av  = ($urandom_range(0, 1) == 1);
            ard = AW'($urandom_range(0, 31));
            if (sb[ard]) ard = '0;
            li  = ($urandom_range(0, 3) == 0);
            lrd = AW'($urandom_range(0, 31));
            if (av && li && lrd == ard) li = 0;
            if (!mv_pend) begin
                mv_pend = ($urandom_range(0, 2) != 0);
                mrd     = AW'($urandom_range(0, 31));
                md      = $urandom;
            end
            step(av, ard, $urandom, li, lrd, mv_pend, mrd, md,
                 AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), acc);
            if (acc) mv_pend = 0;
        end
        idle(4, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side counterpart of the register file: arbitrates ALU results and multi-cycle load results onto the single register-file write port (WE3/ad3/WD3).
- Keeps a pending-load scoreboard and answers decode-stage hazard queries for the read addresses ad1/ad2.
- Sits between execute/memory and the register file; the decode stall logic consumes its `hazard` output.

Parameters:
- ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers).
- DATA_WIDTH, 32, register data width.
- FIFO_DEPTH, 2, load-result buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; always accepted, no ready.
- alu_rd  in  ADDRESS_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_issue  in  1  load issued; marks ld_rd pending.
- ld_rd  in  ADDRESS_WIDTH  issued load destination.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted when mem_valid&mem_ready.
- mem_rd  in  ADDRESS_WIDTH  load result destination.
- mem_data  in  DATA_WIDTH  load result data.
- rs1  in  ADDRESS_WIDTH  decode read address 1 (ad1).
- rs2  in  ADDRESS_WIDTH  decode read address 2 (ad2).
- hazard  out  1  decode must stall.
- WE3  out  1  register-file write enable (registered).
- ad3  out  ADDRESS_WIDTH  write address (registered).
- WD3  out  DATA_WIDTH  write data (registered).

Behaviour:
- Reset: WE3=0, ad3=0, WD3=0, FIFO emptied, scoreboard cleared, mem_ready=0 while rst=1. Reset mid-operation discards buffered loads and pending bits.
- Load results enter a FIFO_DEPTH FIFO on mem_valid&mem_ready. mem_ready = !full, computed from registered state only.
- Selection each cycle: if alu_valid, the ALU result goes to the output register; otherwise the FIFO head is popped if non-empty; otherwise WE3 goes to 0 next cycle.
- Latency: selected at cycle N -> WE3/ad3/WD3 valid in N+1 -> register file written at the end of N+1.
- A load accepted into an empty FIFO with no ALU traffic is popped in the cycle after acceptance (FIFO is not bypassed). Write therefore appears in N+2 from the mem handshake.
- rd=0: the entry is consumed normally but WE3 stays 0 for it. ld_issue with ld_rd=0 sets no bit.
- Scoreboard, 2**ADDRESS_WIDTH bits:
  - Set on ld_issue.
  - Cleared at the edge ending a cycle where WE3=1 and ad3 matches a load-sourced write (output-register tag `is_load`).
  - Set and clear on the same register in the same cycle: set wins.
- hazard = (rs1!=0 & sb[rs1]) | (rs2!=0 & sb[rs2]). Combinational from registered state.
- FIFO full with mem_valid: mem_ready=0, producer holds.
- Simultaneous alu_valid, push and pop: FIFO pops nothing, pushes if not full. Count is the net of push and pop.
- ALU write to a register with its scoreboard bit set is illegal. Decode guarantees this never happens; the bench asserts it.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds outputs byp1_en, byp1_data, byp2_en, byp2_data. bypN_en = WE3 & ad3==rsN & rsN!=0, and byp data = WD3. hazard ignores a source whose byp is active.
- Undefined: no bypass ports; hazard holds through the write cycle and drops the cycle after.

Decomposition:
- Package wb_pkg: wb_entry_t struct {rd, data, is_load}; REG_ZERO constant; default widths.
- Sub-module wb_fifo: parameterised sync FIFO of wb_entry_t with push/pop/full/empty.

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle 1 -> WE3=1, ad3=5, WD3=0xDEADBEEF in cycle 2. All outputs 0 during rst.
- ld_issue rd=7, rs1=7 -> hazard=1. mem result rd=7, data=0x12 accepted at N -> WE3 at N+2, hazard=1 through N+2, 0 at N+3 (bypass off).
- alu_valid held 4 cycles while 3 loads offered -> mem_ready drops after 2 accepts. Loads written in order after ALU stops; no result lost.
- alu_rd=0, data=0xFF -> WE3 stays 0. ld_issue rd=0 -> hazard never asserted for rs1=0.
- 2 loads buffered, rst pulsed 1 cycle -> FIFO empty, scoreboard 0, no writes after reset.
- WB_BYPASS_EN: load rd=3 on the write port, rs2=3 -> byp2_en=1, byp2_data=WD3, hazard=0 in the same cycle.
